// File: rtl/dmem_sized_pipe.sv
// Byte-addressed MEM-stage data memory: byte/half/word loads and stores, zero-fill sweep after reset.
// Loads return READ_LAT cycles after acceptance, one per cycle and in order; ready_o stays low during the sweep.
// Requests made while ready_o is low are dropped. Define DMEM_BOUNDS_CHECK_EN to fault addresses >= DEPTH_BYTES instead of wrapping.
module dmem_sized_pipe #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128,
  parameter int READ_LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       data_o,
  output logic              err_o
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int NW = DEPTH_BYTES / 4;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  clr_idx_q, clr_idx_d;
  logic           clr_en;
  logic [AW-1:0]  clr_base;

  logic [7:0]     mem [DEPTH_BYTES];

  logic [AW-1:0]  eff_addr;
  logic [AW-1:0]  lane_addr [4];
  logic [3:0]     lane_en;
  logic           bad_size, misalign, oob, fault;
  logic           acc, st_acc, ld_acc, st_wr;
  logic [7:0]     b0, b1, b2, b3;
  logic [31:0]    ld_data;

  logic [READ_LAT-1:0] vld_q, lerr_q;
  logic [31:0]         dat_q [READ_LAT];
  logic                st_err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_o   = 1'b0;
    clr_en    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == CW'(NW - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      IDLE:    ready_o = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_base = AW'({clr_idx_q, 2'b00});
  assign eff_addr = addr_i[AW-1:0];

  always_comb begin
    bad_size = (size_i == 2'b11);
    misalign = 1'b0;
    lane_en  = 4'b0000;
    case (size_i)
      2'b00: lane_en = 4'b0001;
      2'b01: begin lane_en = 4'b0011; misalign = addr_i[0];          end
      2'b10: begin lane_en = 4'b1111; misalign = |addr_i[1:0];       end
      default: lane_en = 4'b0000;
    endcase
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = |addr_i[ADDR_W-1:AW];
`else
    oob = 1'b0;
`endif
    fault = bad_size | misalign | oob;
    for (int k = 0; k < 4; k++) lane_addr[k] = eff_addr + AW'(k);
  end

  assign acc    = req_i & ready_o;
  assign st_acc = acc & we_i;
  assign ld_acc = acc & ~we_i;
  assign st_wr  = st_acc & ~fault;

  // Array has no reset; the sweep owns initialisation.
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      for (int k = 0; k < 4; k++) mem[clr_base | AW'(k)] <= 8'h00;
    end else if (st_wr) begin
      for (int k = 0; k < 4; k++)
        if (lane_en[k]) mem[lane_addr[k]] <= data_i[8*k +: 8];
    end
  end

  assign b0 = mem[lane_addr[0]];
  assign b1 = mem[lane_addr[1]];
  assign b2 = mem[lane_addr[2]];
  assign b3 = mem[lane_addr[3]];

  always_comb begin
    ld_data = 32'h0;
    if (!fault) begin
      case (size_i)
        2'b00:   ld_data = {{24{~unsigned_i & b0[7]}}, b0};
        2'b01:   ld_data = {{16{~unsigned_i & b1[7]}}, b1, b0};
        2'b10:   ld_data = {b3, b2, b1, b0};
        default: ld_data = 32'h0;
      endcase
    end
  end

  // Data stages only advance with a valid entry, so the last stage holds between pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q    <= '0;
      lerr_q   <= '0;
      st_err_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= 32'h0;
    end else begin
      vld_q[0]  <= ld_acc;
      lerr_q[0] <= ld_acc & fault;
      st_err_q  <= st_acc & fault;
      if (ld_acc) dat_q[0] <= ld_data;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        lerr_q[i] <= lerr_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rvalid_o = vld_q[READ_LAT-1];
  assign data_o   = dat_q[READ_LAT-1];
  assign err_o    = lerr_q[READ_LAT-1] | st_err_q;

endmodule

// File: tb/tb_dmem_sized_pipe.sv
// Directed bench for dmem_sized_pipe built with READ_LAT=3 and DEPTH_BYTES=128.
module tb_dmem_sized_pipe;

  localparam int LAT = 3;

  logic        clk_i, rst_i, req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, data_i;
  logic        ready_o, rvalid_o, err_o;
  logic [31:0] data_o;

  int tests = 0;
  int fails = 0;

  dmem_sized_pipe #(.ADDR_W(32), .DEPTH_BYTES(128), .READ_LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .data_i(data_i), .ready_o(ready_o),
    .rvalid_o(rvalid_o), .data_o(data_o), .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Issues one load; returns the data/err seen with rvalid_o and the sample count (1 = cycle after accept).
  task automatic load_op(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         output logic [31:0] d, output logic e, output int lat);
    req_i = 1'b1; we_i = 1'b0; size_i = sz; unsigned_i = uns; addr_i = a;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    lat = 0; d = 32'h0; e = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (rvalid_o) begin
        lat = i; d = data_o; e = err_o;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic store_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          output logic e);
    req_i = 1'b1; we_i = 1'b1; size_i = sz; unsigned_i = 1'b0; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0;
    e = err_o;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e; int lat; int n;
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
    addr_i = '0; data_i = '0;
    @(posedge clk_i); @(posedge clk_i); #1;
    tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready_o); end
    tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_o); end
    tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", data_o); end
    rst_i = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      n = i;
      if (ready_o) break;
    end
    tests++; if (n !== 32) begin fails++; $display("FAIL sweep_len got %0d want 32", n); end
    load_op(32'h7C, 2'b10, 1'b0, d, e, lat);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL lw_7c_data got %h want 00000000", d); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL lw_7c_lat got %0d want %0d", lat, LAT); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL lw_7c_err got %b want 0", e); end
  endtask

  task automatic test_sized_loads();
    logic [31:0] d; logic e; int lat;
    logic [31:0] ad [5]  = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [1:0]  sz [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        un [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex [5]  = '{32'hFFFFFFBB, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    store_op(32'h10, 32'h8899AABB, 2'b10, e);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL sw_10_err got %b want 0", e); end
    for (int k = 0; k < 5; k++) begin
      load_op(ad[k], sz[k], un[k], d, e, lat);
      tests++; if (d !== ex[k]) begin fails++; $display("FAIL sized_load%0d got %h want %h", k, d, ex[k]); end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL sized_lat%0d got %0d want %0d", k, lat, LAT); end
    end
    @(posedge clk_i); #1; @(posedge clk_i); #1;
    tests++; if (rvalid_o !== 1'b0 || data_o !== 32'h8899AABB) begin
      fails++; $display("FAIL data_hold got rvalid=%b data=%h want 0/8899aabb", rvalid_o, data_o);
    end
    store_op(32'h11, 32'h00000055, 2'b00, e);
    load_op(32'h10, 2'b10, 1'b0, d, e, lat);
    tests++; if (d !== 32'h889955BB) begin fails++; $display("FAIL sb_merge got %h want 889955bb", d); end
  endtask

  task automatic test_back_to_back();
    logic e; logic [31:0] d; int lat;
    logic        s_we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] s_ad [4] = '{32'h00, 32'h04, 32'h04, 32'h08};
    logic        x_rv [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] x_d  [8] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h0, 32'h33333333, 32'h0, 32'h0};
    store_op(32'h00, 32'h11111111, 2'b10, e);
    store_op(32'h04, 32'h22222222, 2'b10, e);
    store_op(32'h08, 32'h33333333, 2'b10, e);
    req_i = 1'b1; we_i = s_we[0]; addr_i = s_ad[0]; size_i = 2'b10; data_i = 32'h1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk_i); #1;
      if (j < 3) begin
        we_i = s_we[j+1]; addr_i = s_ad[j+1];
      end else begin
        req_i = 1'b0; we_i = 1'b0;
      end
      tests++; if (rvalid_o !== x_rv[j]) begin fails++; $display("FAIL b2b_rvalid%0d got %b want %b", j, rvalid_o, x_rv[j]); end
      if (x_rv[j]) begin
        tests++; if (data_o !== x_d[j]) begin fails++; $display("FAIL b2b_data%0d got %h want %h", j, data_o, x_d[j]); end
      end
    end
    load_op(32'h04, 2'b10, 1'b0, d, e, lat);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL b2b_store_landed got %h want 00000001", d); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic e; int lat;
    store_op(32'h20, 32'hCAFEF00D, 2'b10, e);
    store_op(32'h21, 32'h0000BEEF, 2'b01, e);
    tests++; if (e !== 1'b1 || rvalid_o !== 1'b0) begin
      fails++; $display("FAIL sh_21_err got err=%b rvalid=%b want 1/0", e, rvalid_o);
    end
    @(posedge clk_i); #1;
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_pulse_width got %b want 0", err_o); end
    load_op(32'h20, 2'b10, 1'b0, d, e, lat);
    tests++; if (d !== 32'hCAFEF00D) begin fails++; $display("FAIL sh_21_nowrite got %h want cafef00d", d); end
    load_op(32'h22, 2'b10, 1'b0, d, e, lat);
    tests++; if (d !== 32'h0 || e !== 1'b1 || lat !== LAT) begin
      fails++; $display("FAIL lw_22_fault got data=%h err=%b lat=%0d want 0/1/%0d", d, e, lat, LAT);
    end
    load_op(32'h20, 2'b11, 1'b0, d, e, lat);
    tests++; if (d !== 32'h0 || e !== 1'b1) begin
      fails++; $display("FAIL rsvd_size got data=%h err=%b want 0/1", d, e);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic e; int lat;
    store_op(32'h04, 32'h12345678, 2'b10, e);
    store_op(32'h84, 32'hDEADBEEF, 2'b10, e);
    load_op(32'h04, 2'b10, 1'b0, d, e, lat);
`ifdef DMEM_BOUNDS_CHECK_EN
    tests++; if (d !== 32'h12345678) begin fails++; $display("FAIL oob_nowrite got %h want 12345678", d); end
`else
    tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL wrap got %h want deadbeef", d); end
`endif
  endtask

  task automatic test_reset_midread();
    logic [31:0] d; logic e; int lat; int n; logic seen_rv;
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h10;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    tests++; if (rvalid_o !== 1'b0 || ready_o !== 1'b0) begin
      fails++; $display("FAIL midread_async got rvalid=%b ready=%b want 0/0", rvalid_o, ready_o);
    end
    @(posedge clk_i); #1;
    tests++; if (rvalid_o !== 1'b0) begin fails++; $display("FAIL midread_dropped got %b want 0", rvalid_o); end
    rst_i = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    n = 0; seen_rv = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      n = i;
      if (rvalid_o) seen_rv = 1'b1;
      if (ready_o) begin req_i = 1'b0; break; end
    end
    tests++; if (n !== 32) begin fails++; $display("FAIL resweep_len got %0d want 32", n); end
    tests++; if (seen_rv !== 1'b0) begin fails++; $display("FAIL req_during_sweep got rvalid want none"); end
    load_op(32'h10, 2'b10, 1'b0, d, e, lat);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL resweep_clear got %h want 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_sized_loads();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
